binary_counter_bank: RTL and testbench
======================================

# binary_counter_bank

Bank of three enable-gated 4-bit up-counters sharing one clock, one reset and one enable. The three counters are built three different ways: a control/datapath-partitioned binary counter, a partitioned counter that steps by 3, and a monolithic explicit-state FSM counter. The block serves as the counter-style comparison unit: the binary and FSM counters must always agree cycle for cycle, and the step-3 counter provides a distinct arithmetic sequence.

## Interface
- WIDTH, 4, counter width; all counts wrap modulo 2^WIDTH.
- STEP, 3, increment applied by the step counter per enabled cycle.

- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- enable  input  1  count enable; sampled on the rising clk edge.
- count_bin  output  WIDTH  partitioned binary counter value.
- count_step  output  WIDTH  partitioned step counter value (+STEP per enabled cycle).
- count_fsm  output  WIDTH  explicit-state FSM counter value.
- bin_active  output  1  binary counter controller state (1 = S_COUNTING, 0 = S_IDLE).

## Operation
- **Partitioned binary counter**
  - Controller FSM has two states, S_IDLE and S_COUNTING.
  - From S_IDLE: enable=1 moves to S_COUNTING and asserts incr combinationally in that same cycle. enable=0 stays in S_IDLE.
  - From S_COUNTING: enable=1 stays and asserts incr. enable=0 returns to S_IDLE with no incr.
  - Datapath register: count_bin <= count_bin + 1 when incr=1, otherwise holds.
  - The net effect is that every rising edge with enable=1 increments the count, including the first edge after leaving idle.
- **Partitioned step counter**
  - Uses the same two-state controller structure, with its own state register.
  - Datapath: count_step <= (count_step + STEP) mod 2^WIDTH on each incr.
  - Sum is truncated to WIDTH; there is no saturation and no carry out.
- **FSM counter**
  - Single always-block FSM with 2^WIDTH states S0..S15, where state encoding equals the output value.
  - Sk goes to S(k+1 mod 16) when enable=1, otherwise stays in Sk.
  - count_fsm is driven directly from the state register (Moore, registered).
- **Wrap-around:** count_bin and count_fsm go 15→0. count_step follows 0,3,6,9,12,15,2,5,…
- **Cross-check invariant:** count_fsm == count_bin at all times.
- No load, clear or down-count function exists; rst is the only way to return to zero.

## Timing
- **Reset** (rst=0, asynchronous, takes effect immediately with no clock needed):
  - count_bin=0, count_step=0, count_fsm=0.
  - bin_active=0; both controllers in S_IDLE.
  - Reset wins over enable at all times.
- **Reset release:** the first rising edge with rst=1 and enable=1 increments.
- **Latency:** one clock. A count changes on the same rising edge at which enable=1 is sampled, and the output is valid after that edge.
- **Enable deassert:** counts hold their value from the next edge onward. Toggling enable causes no loss or duplication of counts.
- **bin_active** updates on the same edge as the state transition.
- **Mid-count reset:** all outputs clear asynchronously. Counting resumes from 0 after release.
- All outputs are registered, with no combinational path from enable to the count outputs.

## Test plan
- **Reset:** rst=0 for 3 cycles with enable=1 → all counts 0, bin_active=0. Assert rst=0 asynchronously mid-cycle while counting → outputs go to 0 before the next edge.
- **Basic counting:** release rst and keep enable=0 for 2 cycles → all hold 0. Then enable=1 for 18 edges → count_bin=2, count_fsm=2, count_step=6, bin_active=1.
- **Hold and resume:** continuing from the previous scenario, enable=0 for 5 edges → values unchanged, bin_active=0. Then enable=1 for 5 edges → count_bin=7, count_fsm=7, count_step=5.
- **Wrap boundary:** from reset, apply 15 enabled edges → count_bin=15 and count_step=13. One more edge → count_bin=0, count_fsm=0, count_step=0.
- **Random enable:** random enable pattern over 200 cycles, with the bench checking each cycle:
  - count_fsm == count_bin;
  - count_step == (3 × count of enabled edges) mod 16;
  - count_bin == (count of enabled edges) mod 16.
- **Single-cycle pulse:** enable high for exactly 1 edge from idle → all counts advance by exactly one step, and bin_active pulses high for 1 cycle.

Source files
------------

// File: rtl/binary_counter_bank.sv
// Three enable-gated up-counters built three ways: partitioned binary, partitioned step-by-STEP, explicit-state FSM.
// Latency: one clock from a sampled enable to every count output; the block never stalls.
module binary_counter_bank #(
  parameter int WIDTH = 4,
  parameter int STEP  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  output logic [WIDTH-1:0] count_bin,
  output logic [WIDTH-1:0] count_step,
  output logic [WIDTH-1:0] count_fsm,
  output logic             bin_active
);

  typedef enum logic {S_IDLE = 1'b0, S_COUNTING = 1'b1} ctrl_state_e;

  typedef enum logic [3:0] {
    S0,  S1,  S2,  S3,  S4,  S5,  S6,  S7,
    S8,  S9,  S10, S11, S12, S13, S14, S15
  } fsm_state_e;

  ctrl_state_e bin_state, bin_state_nxt;
  ctrl_state_e step_state, step_state_nxt;
  logic        bin_incr, step_incr;

  fsm_state_e  fsm_state, fsm_state_nxt;

  logic [WIDTH-1:0] bin_reg, step_reg;

  // Controllers: incr is combinational so the edge that leaves idle also counts.
  always_comb begin
    bin_state_nxt = bin_state;
    bin_incr      = 1'b0;
    case (bin_state)
      S_IDLE: begin
        if (enable) begin
          bin_state_nxt = S_COUNTING;
          bin_incr      = 1'b1;
        end
      end
      S_COUNTING: begin
        if (enable) bin_incr = 1'b1;
        else        bin_state_nxt = S_IDLE;
      end
      default: bin_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    step_state_nxt = step_state;
    step_incr      = 1'b0;
    case (step_state)
      S_IDLE: begin
        if (enable) begin
          step_state_nxt = S_COUNTING;
          step_incr      = 1'b1;
        end
      end
      S_COUNTING: begin
        if (enable) step_incr = 1'b1;
        else        step_state_nxt = S_IDLE;
      end
      default: step_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bin_state  <= S_IDLE;
      step_state <= S_IDLE;
      bin_reg    <= '0;
      step_reg   <= '0;
    end else begin
      bin_state  <= bin_state_nxt;
      step_state <= step_state_nxt;
      if (bin_incr)  bin_reg  <= bin_reg + WIDTH'(1);
      if (step_incr) step_reg <= step_reg + WIDTH'(STEP);
    end
  end

  // State encoding equals the count, so the output is the state register itself.
  always_comb begin
    fsm_state_nxt = fsm_state;
    if (enable) begin
      case (fsm_state)
        S0:  fsm_state_nxt = S1;
        S1:  fsm_state_nxt = S2;
        S2:  fsm_state_nxt = S3;
        S3:  fsm_state_nxt = S4;
        S4:  fsm_state_nxt = S5;
        S5:  fsm_state_nxt = S6;
        S6:  fsm_state_nxt = S7;
        S7:  fsm_state_nxt = S8;
        S8:  fsm_state_nxt = S9;
        S9:  fsm_state_nxt = S10;
        S10: fsm_state_nxt = S11;
        S11: fsm_state_nxt = S12;
        S12: fsm_state_nxt = S13;
        S13: fsm_state_nxt = S14;
        S14: fsm_state_nxt = S15;
        S15: fsm_state_nxt = S0;
        default: fsm_state_nxt = S0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) fsm_state <= S0;
    else      fsm_state <= fsm_state_nxt;
  end

  assign count_bin  = bin_reg;
  assign count_step = step_reg;
  assign count_fsm  = fsm_state;
  assign bin_active = (bin_state == S_COUNTING);

endmodule

// File: tb/tb_binary_counter_bank.sv
// Directed and random-enable checks of the three counters against hand-computed values and a small model.
module tb_binary_counter_bank;

  logic       clk;
  logic       rst;
  logic       enable;
  logic [3:0] count_bin;
  logic [3:0] count_step;
  logic [3:0] count_fsm;
  logic       bin_active;

  int n_cmp;
  int n_err;

  binary_counter_bank #(.WIDTH(4), .STEP(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .count_bin  (count_bin),
    .count_step (count_step),
    .count_fsm  (count_fsm),
    .bin_active (bin_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Drive enable at the falling edge, run n rising edges, return at a falling edge.
  task automatic run(input int n, input logic en);
    for (int i = 0; i < n; i++) begin
      enable = en;
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic chk_all(input string tag, input int b, input int s, input int f);
    chk({tag, "_bin"},  32'(count_bin),  32'(b));
    chk({tag, "_step"}, 32'(count_step), 32'(s));
    chk({tag, "_fsm"},  32'(count_fsm),  32'(f));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    enable = 1'b0;
    rst = 1'b1;
  endtask

  initial begin
    int n_en;
    n_cmp  = 0;
    n_err  = 0;
    rst    = 1'b0;
    enable = 1'b1;

    // Reset held with enable high
    repeat (3) @(negedge clk);
    chk_all("rst", 0, 0, 0);
    chk("rst_active", 32'(bin_active), 32'd0);

    rst = 1'b1;
    run(2, 1'b0);
    chk_all("idle_hold", 0, 0, 0);

    run(18, 1'b1);
    chk_all("cnt18", 2, 6, 2);
    chk("cnt18_active", 32'(bin_active), 32'd1);

    run(5, 1'b0);
    chk_all("hold5", 2, 6, 2);
    chk("hold5_active", 32'(bin_active), 32'd0);

    run(5, 1'b1);
    chk_all("resume5", 7, 5, 7);

    // Asynchronous reset in the middle of a high clock phase
    enable = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk_all("async_rst", 0, 0, 0);
    chk("async_rst_active", 32'(bin_active), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    enable = 1'b0;

    // Wrap boundary from a clean reset
    do_reset();
    run(15, 1'b1);
    chk_all("pre_wrap", 15, 13, 15);
    run(1, 1'b1);
    chk_all("wrap", 0, 0, 0);

    // Single-cycle enable pulse from idle
    run(2, 1'b0);
    chk("idle_active", 32'(bin_active), 32'd0);
    run(1, 1'b1);
    chk_all("pulse", 1, 3, 1);
    chk("pulse_active_hi", 32'(bin_active), 32'd1);
    run(1, 1'b0);
    chk_all("pulse_after", 1, 3, 1);
    chk("pulse_active_lo", 32'(bin_active), 32'd0);

    // Random enable pattern against a running model of enabled edges
    do_reset();
    n_en = 0;
    for (int c = 0; c < 200; c++) begin
      logic en;
      en = 1'($urandom_range(0, 1));
      run(1, en);
      if (en) n_en++;
      chk("rnd_fsm_eq_bin", 32'(count_fsm),  32'(count_bin));
      chk("rnd_bin",        32'(count_bin),  32'(n_en % 16));
      chk("rnd_step",       32'(count_step), 32'((3 * n_en) % 16));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
